error_log_queue: RTL and testbench
==================================

ERROR_LOG_QUEUE -- requirements
Module: error_log_queue

Interface
REQ-001 Parameter DEPTH, default 8, meaning number of log entries (power of two, at least 2).
REQ-002 Parameter TS_WIDTH, default 16, meaning timestamp counter width.
REQ-003 Parameter HOLDOFF_CYCLES, default 64, meaning minimum number of cycles between irq_ack and irq re-assertion.
REQ-004 The block SHALL use clock clk; reset rst_n is asynchronous, active-low.
REQ-005 The block SHALL have these ports:
- clk  input  1  clock
- rst_n  input  1  async active-low reset
- err_valid  input  1  error event strobe from the error-detection stage
- err_code  input  8  error code; 8'h00 means none
- err_txn_id  input  12  transaction ID of the event
- err_addr  input  48  address of the event
- rd_valid  output  1  head entry available
- rd_ready  input  1  consumer pops the head entry
- rd_code  output  8  head entry code
- rd_txn_id  output  12  head entry transaction ID
- rd_addr  output  48  head entry address
- rd_timestamp  output  TS_WIDTH  head entry capture time
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky flag: an event was dropped
- drop_count  output  8  saturating count of dropped events
- clr_overflow  input  1  clears overflow and drop_count
- irq_en  input  1  interrupt enable
- irq_ack  input  1  interrupt acknowledge
- irq  output  1  level interrupt

Function
REQ-006 An event SHALL be accepted when err_valid=1 and err_code!=0; err_valid with err_code=0 SHALL be ignored.
REQ-007 An accepted event SHALL be written to the tail as {code, txn_id, addr, ts}, where ts is the free-running timestamp value in the accept cycle.
REQ-008 The timestamp SHALL increment every cycle and wrap from all-ones to 0.
REQ-009 rd_valid SHALL equal (count!=0); rd_* SHALL show the head entry combinationally from storage.
REQ-010 Push-to-read latency SHALL be 1 cycle: an event accepted in cycle N is visible on rd_* in cycle N+1 when the queue was empty.
REQ-011 A pop SHALL occur when rd_valid && rd_ready; rd_ready while empty SHALL have no effect.
REQ-012 Full queue with push and pop in the same cycle: the pop and the push SHALL both take effect, count SHALL be unchanged, and no drop SHALL occur.
REQ-013 Full queue with push and no pop: the event SHALL be discarded, overflow set to 1, and drop_count incremented, saturating at 255.
REQ-014 Simultaneous push and pop with 0<count<DEPTH: count SHALL be unchanged.
REQ-015 clr_overflow SHALL clear overflow and drop_count on the next edge.
REQ-016 A drop in the same cycle as clr_overflow SHALL take priority, giving overflow=1 and drop_count=1.
REQ-017 Pointers SHALL wrap modulo DEPTH.
REQ-018 The interrupt FSM SHALL have states IDLE, PEND and HOLD, with irq=1 only in PEND.
REQ-019 IDLE->PEND SHALL occur when irq_en && (count!=0 || overflow).
REQ-020 PEND->HOLD SHALL occur on irq_ack and load the holdoff timer with HOLDOFF_CYCLES-1.
REQ-021 PEND->IDLE SHALL occur when irq_en=0; irq_en=0 SHALL take priority over a simultaneous irq_ack.
REQ-022 In HOLD the timer SHALL decrement each cycle, move to IDLE when it reaches 0, and ignore irq_ack.
REQ-023 irq_ack in IDLE SHALL be ignored.

Reset
REQ-024 On reset, count=0, rd_valid=0, pointers=0, timestamp=0, overflow=0, drop_count=0, FSM=IDLE, irq=0, and rd_* outputs SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately, with no pop and no irq generated.

Structure
REQ-026 The error_code_e enum (NONE=00, CRC_MISMATCH=01, TIMEOUT=02, INVALID_OPCODE=03, INVALID_VC=04, BUFFER_OVERFLOW=05, PROTOCOL=06) and the err_log_entry_t struct SHALL live in coh_noc_pkg.
REQ-027 Storage SHALL be one sub-module, err_log_fifo (a synchronous FIFO with simultaneous push and pop when full); the FSM and counters SHALL live in the top level.

Verification
REQ-028 After reset, push code=02 txn=0x0A5 addr=0x1234 at cycle 5: at cycle 6 rd_valid=1, rd_txn_id=0x0A5, rd_timestamp=5; with irq_en=1, irq=1 at cycle 7.
REQ-029 Push 9 events with DEPTH=8 and rd_ready=0: count=8, overflow=1, drop_count=1; popping 8 entries returns txn IDs 1..8 in order.
REQ-030 Full queue, then push and pop in the same cycle: count stays 8, overflow=0, and the new entry is last out.
REQ-031 irq=1, pulse irq_ack: irq=0 for exactly 64 cycles, then re-asserts while count!=0.
REQ-032 Drive 300 drops: drop_count=255; clr_overflow together with a drop gives drop_count=1, overflow=1.
REQ-033 Assert rst_n=0 with count=5 and irq=1: count=0 and irq=0 asynchronously; err_valid with code=00 never changes count.

Source files
------------

// File: rtl/coh_noc_pkg.sv
// Shared types for the coherent NoC error logging path.
// Error codes, log entry layout and interrupt FSM states.
package coh_noc_pkg;

    typedef enum logic [7:0] {
        NONE            = 8'h00,
        CRC_MISMATCH    = 8'h01,
        TIMEOUT         = 8'h02,
        INVALID_OPCODE  = 8'h03,
        INVALID_VC      = 8'h04,
        BUFFER_OVERFLOW = 8'h05,
        PROTOCOL        = 8'h06
    } error_code_e;

    // Payload of one log entry; the timestamp is appended next to it
    // in storage because its width is a per-instance parameter.
    typedef struct packed {
        logic [7:0]  code;
        logic [11:0] txn_id;
        logic [47:0] addr;
    } err_log_entry_t;

    localparam int ENTRY_W = $bits(err_log_entry_t);

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_PEND,
        IRQ_HOLD
    } irq_state_e;

    function automatic logic is_event(input logic v,
                                      input logic [7:0] code);
        return v && (code != NONE);
    endfunction

endpackage

// File: rtl/err_log_fifo.sv
// Synchronous FIFO holding error log entries.
// Ports: push/wdata write the tail, pop/rdata read the head, count = occupancy.
module err_log_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;
    logic          empty;
    logic          full;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    // Empty FIFO shows zeros rather than stale storage.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/error_log_queue.sv
// Error log queue: timestamps error events into a FIFO, tracks drops,
// and raises a level interrupt with an ack holdoff.
// Ports: err_* event in, rd_* head entry out with rd_ready pop,
// count/overflow/drop_count status, clr_overflow, irq_en/irq_ack/irq.
module error_log_queue
    import coh_noc_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TS_WIDTH       = 16,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     err_valid,
    input  logic [7:0]               err_code,
    input  logic [11:0]              err_txn_id,
    input  logic [47:0]              err_addr,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [7:0]               rd_code,
    output logic [11:0]              rd_txn_id,
    output logic [47:0]              rd_addr,
    output logic [TS_WIDTH-1:0]      rd_timestamp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic                     clr_overflow,
    input  logic                     irq_en,
    input  logic                     irq_ack,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = ENTRY_W + TS_WIDTH;
    localparam int TW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    logic [TS_WIDTH-1:0] ts;
    logic                accept;
    logic                pop;
    logic                full;
    logic                drop;
    logic                fifo_push;
    err_log_entry_t      wr_entry;
    err_log_entry_t      rd_entry;
    logic [FW-1:0]       wdata;
    logic [FW-1:0]       rdata;
    irq_state_e          state_q;
    irq_state_e          state_d;
    logic [TW-1:0]       timer_q;

    assign accept    = is_event(err_valid, err_code);
    assign rd_valid  = (count != '0);
    assign pop       = rd_valid && rd_ready;
    assign full      = (count == CW'(DEPTH));
    assign drop      = accept && full && !pop;
    assign fifo_push = accept && !drop;

    assign wr_entry = '{code: err_code, txn_id: err_txn_id, addr: err_addr};
    assign wdata    = {wr_entry, ts};

    err_log_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count)
    );

    assign rd_entry     = rdata[FW-1:TS_WIDTH];
    assign rd_timestamp = rdata[TS_WIDTH-1:0];
    assign rd_code      = rd_entry.code;
    assign rd_txn_id    = rd_entry.txn_id;
    assign rd_addr      = rd_entry.addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
        end
    end

    // A drop wins over a simultaneous clear and restarts the count at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IRQ_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IRQ_PEND && state_d == IRQ_HOLD) begin
                timer_q <= TW'(HOLDOFF_CYCLES - 1);
            end else if (state_q == IRQ_HOLD && timer_q != '0) begin
                timer_q <= timer_q - TW'(1);
            end
        end
    end

    // HOLD leaves as the timer steps down to zero, so HOLD plus the
    // single IDLE cycle keep irq low for exactly HOLDOFF_CYCLES.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IRQ_IDLE: begin
                if (irq_en && (rd_valid || overflow)) begin
                    state_d = IRQ_PEND;
                end
            end
            IRQ_PEND: begin
                if (!irq_en) begin
                    state_d = IRQ_IDLE;
                end else if (irq_ack) begin
                    state_d = IRQ_HOLD;
                end
            end
            IRQ_HOLD: begin
                if (timer_q <= TW'(1)) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        irq = (state_q == IRQ_PEND);
    end

endmodule

// File: tb/tb_error_log_queue.sv
// Testbench for error_log_queue: directed scenarios plus random traffic
// against a queue-based reference model and a scoreboard monitor.
module tb_error_log_queue;

    localparam int DEPTH   = 8;
    localparam int TSW     = 16;
    localparam int HOLDOFF = 64;

    logic        clk;
    logic        rst_n;
    logic        err_valid;
    logic [7:0]  err_code;
    logic [11:0] err_txn_id;
    logic [47:0] err_addr;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_code;
    logic [11:0] rd_txn_id;
    logic [47:0] rd_addr;
    logic [15:0] rd_timestamp;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clr_overflow;
    logic        irq_en;
    logic        irq_ack;
    logic        irq;

    error_log_queue #(
        .DEPTH          (DEPTH),
        .TS_WIDTH       (TSW),
        .HOLDOFF_CYCLES (HOLDOFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .err_txn_id   (err_txn_id),
        .err_addr     (err_addr),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_code      (rd_code),
        .rd_txn_id    (rd_txn_id),
        .rd_addr      (rd_addr),
        .rd_timestamp (rd_timestamp),
        .count        (count),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clr_overflow (clr_overflow),
        .irq_en       (irq_en),
        .irq_ack      (irq_ack),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic [11:0] txn;
        logic [47:0] addr;
        logic [15:0] ts;
    } ent_t;

    int checks = 0;
    int errors = 0;

    ent_t        exp_q[$];
    logic [11:0] popped[$];

    int          m_count;
    bit          m_ovf;
    int          m_drop;
    logic [15:0] m_ts;
    bit          m_irq;
    int          m_quiet;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (irq) break;
            n++;
            if (n >= budget) begin
                fail_now("irq_wait_timeout");
                break;
            end
        end
        tick();
    endtask

    task automatic push_ev(input logic [11:0] txn);
        err_valid  = 1'b1;
        err_code   = 8'(1 + (txn % 6));
        err_txn_id = txn;
        err_addr   = {36'h0, txn} ^ 48'hA5A5_0000_1000;
        tick();
    endtask

    // Reference model: the log as a list of entries, drops and the
    // interrupt as a pending flag plus a quiet-time counter.
    always @(posedge clk or negedge rst_n) begin : model
        bit ev;
        bit pp;
        bit dr;
        if (!rst_n) begin
            m_count <= 0;
            m_ovf   <= 1'b0;
            m_drop  <= 0;
            m_ts    <= '0;
            m_irq   <= 1'b0;
            m_quiet <= 0;
            exp_q.delete();
        end else begin
            ev = err_valid && (err_code != 8'h00);
            pp = (m_count != 0) && rd_ready;
            dr = ev && (m_count == DEPTH) && !pp;
            if (ev && !dr) begin
                exp_q.push_back('{err_code, err_txn_id, err_addr, m_ts});
            end
            m_count <= m_count + ((ev && !dr) ? 1 : 0) - (pp ? 1 : 0);
            if (dr) begin
                m_ovf  <= 1'b1;
                m_drop <= clr_overflow ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
            end else if (clr_overflow) begin
                m_ovf  <= 1'b0;
                m_drop <= 0;
            end
            m_ts <= m_ts + 16'd1;
            if (m_irq) begin
                if (!irq_en) begin
                    m_irq <= 1'b0;
                end else if (irq_ack) begin
                    m_irq   <= 1'b0;
                    m_quiet <= HOLDOFF - 1;
                end
            end else if (m_quiet > 0) begin
                m_quiet <= m_quiet - 1;
            end else begin
                m_irq <= irq_en && (m_count != 0 || m_ovf);
            end
        end
    end

    always @(negedge clk) begin : monitor
        ent_t e;
        if (rst_n) begin
            chk("count", 64'(count), 64'(m_count));
            chk("rd_valid", 64'(rd_valid), 64'(m_count != 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("drop_count", 64'(drop_count), 64'(m_drop));
            chk("irq", 64'(irq), 64'(m_irq));
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("pop_with_no_expected_entry");
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_code", 64'(rd_code), 64'(e.code));
                    chk("rd_txn_id", 64'(rd_txn_id), 64'(e.txn));
                    chk("rd_addr", 64'(rd_addr), 64'(e.addr));
                    chk("rd_timestamp", 64'(rd_timestamp), 64'(e.ts));
                    popped.push_back(rd_txn_id);
                end
            end
        end
    end

    initial begin
        logic [63:0] r;
        int lows;
        rst_n        = 1'b0;
        err_valid    = 1'b0;
        err_code     = 8'h00;
        err_txn_id   = '0;
        err_addr     = '0;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
        irq_en       = 1'b1;
        irq_ack      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state, cycle 0.
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_txn", 64'(rd_txn_id), 64'd0);
        chk("rst_rd_ts", 64'(rd_timestamp), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);

        // First push at cycle 5.
        repeat (5) @(posedge clk);
        #1;
        err_valid  = 1'b1;
        err_code   = 8'h02;
        err_txn_id = 12'h0A5;
        err_addr   = 48'h1234;
        tick();
        err_valid = 1'b0;
        @(negedge clk);
        chk("c6_rd_valid", 64'(rd_valid), 64'd1);
        chk("c6_rd_txn", 64'(rd_txn_id), 64'h0A5);
        chk("c6_rd_ts", 64'(rd_timestamp), 64'd5);
        chk("c6_irq", 64'(irq), 64'd0);
        tick();
        @(negedge clk);
        chk("c7_irq", 64'(irq), 64'd1);
        tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;

        // Nine pushes into eight slots.
        irq_en = 1'b0;
        for (int i = 1; i <= 9; i++) push_ev(12'(i));
        err_valid = 1'b0;
        @(negedge clk);
        chk("ovf9_count", 64'(count), 64'd8);
        chk("ovf9_overflow", 64'(overflow), 64'd1);
        chk("ovf9_drop", 64'(drop_count), 64'd1);
        tick();
        popped.delete();
        rd_ready = 1'b1;
        repeat (8) tick();
        rd_ready = 1'b0;
        if (popped.size() != 8) fail_now("ovf9_pop_len");
        for (int i = 0; i < popped.size(); i++)
            chk("ovf9_order", 64'(popped[i]), 64'(i + 1));
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;

        // Full queue with push and pop together.
        for (int i = 0; i < 8; i++) push_ev(12'(8'h11 + i));
        rd_ready = 1'b1;
        push_ev(12'h1FF);
        err_valid = 1'b0;
        rd_ready  = 1'b0;
        @(negedge clk);
        chk("pp_count", 64'(count), 64'd8);
        chk("pp_overflow", 64'(overflow), 64'd0);
        chk("pp_drop", 64'(drop_count), 64'd0);
        tick();
        popped.delete();
        rd_ready = 1'b1;
        repeat (8) tick();
        rd_ready = 1'b0;
        if (popped.size() != 8) fail_now("pp_pop_len");
        else begin
            chk("pp_first", 64'(popped[0]), 64'h012);
            chk("pp_last", 64'(popped[7]), 64'h1FF);
        end

        // Holdoff after acknowledge.
        for (int i = 0; i < 8; i++) push_ev(12'(12'h300 + i));
        err_valid = 1'b0;
        irq_en    = 1'b1;
        wait_irq(10);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        lows    = 0;
        forever begin
            @(negedge clk);
            if (irq) break;
            lows++;
            if (lows > 200) begin
                fail_now("holdoff_timeout");
                break;
            end
        end
        chk("holdoff_lows", 64'(lows), 64'(HOLDOFF));
        tick();

        // Saturating drops and clear-vs-drop priority.
        err_valid  = 1'b1;
        err_code   = 8'h05;
        err_txn_id = 12'h777;
        repeat (300) tick();
        @(negedge clk);
        chk("sat_drop", 64'(drop_count), 64'd255);
        chk("sat_ovf", 64'(overflow), 64'd1);
        tick();
        clr_overflow = 1'b1;
        tick();
        err_valid = 1'b0;
        @(negedge clk);
        chk("clrdrop_drop", 64'(drop_count), 64'd1);
        chk("clrdrop_ovf", 64'(overflow), 64'd1);
        tick();
        clr_overflow = 1'b0;
        @(negedge clk);
        chk("clr_drop", 64'(drop_count), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        tick();

        // Asynchronous reset mid-operation.
        rd_ready = 1'b1;
        repeat (3) tick();
        rd_ready = 1'b0;
        wait_irq(10);
        @(negedge clk);
        chk("prerst_count", 64'(count), 64'd5);
        chk("prerst_irq", 64'(irq), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_irq", 64'(irq), 64'd0);
        chk("arst_rd_valid", 64'(rd_valid), 64'd0);
        chk("arst_rd_txn", 64'(rd_txn_id), 64'd0);
        tick();
        rst_n     = 1'b1;
        err_valid = 1'b1;
        err_code  = 8'h00;
        repeat (20) tick();
        err_valid = 1'b0;
        @(negedge clk);
        chk("code0_count", 64'(count), 64'd0);
        chk("code0_rd_valid", 64'(rd_valid), 64'd0);
        tick();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            r            = {$urandom, $urandom};
            err_valid    = 1'($urandom_range(0, 1));
            err_code     = 8'($urandom_range(0, 6));
            err_txn_id   = r[59:48];
            err_addr     = r[47:0];
            rd_ready     = (c % 400 < 200) ? ($urandom_range(0, 3) == 0)
                                           : ($urandom_range(0, 3) != 0);
            irq_en       = ($urandom_range(0, 9) != 0);
            irq_ack      = ($urandom_range(0, 7) == 0);
            clr_overflow = ($urandom_range(0, 31) == 0);
            tick();
        end
        err_valid    = 1'b0;
        irq_ack      = 1'b0;
        clr_overflow = 1'b0;
        rd_ready     = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        chk("drain_count", 64'(count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
